// File: rtl/err_monitor.sv
// Error indicator front end: masks and registers error strobes, stretches them into a visible
// hold level, and keeps a saturating count, a sticky flag and the first-firing source set.
module err_monitor #(
  parameter int unsigned NERR       = 8,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned MXPRE      = 24,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NERR-1:0] i_err_in,
  input  logic [NERR-1:0] i_err_mask,
  input  logic            i_clear,
  output logic            o_err,
  output logic            o_err_pulse,
  output logic            o_err_sticky,
  output logic [CNTW-1:0] o_err_cnt,
  output logic [NERR-1:0] o_first_src
);

  localparam int unsigned HW = 4;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_nxt;
  logic [NERR-1:0] r_err_r;
  logic [MXPRE-1:0] r_pre;
  logic            w_hit;
  logic            w_tick;

  logic            w_err_nxt;
  logic            w_pulse_nxt;
  logic            w_sticky_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [NERR-1:0] w_first_nxt;

  assign w_hit  = |r_err_r;
  assign w_tick = &r_pre;

  // Stage 1 capture and the free-running hold prescaler (clear does not touch either)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_r <= '0;
      r_pre   <= '0;
    end else begin
      r_err_r <= i_err_in & i_err_mask;
      r_pre   <= r_pre + MXPRE'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Hold FSM: a hit always reloads, so a coincident tick never decrements
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = HW'(HOLD_TICKS);
          end
        end
        S_HOLD: begin
          if (w_hit) begin
            w_hold_nxt = HW'(HOLD_TICKS);
          end else if (w_tick) begin
            if (r_hold_cnt == HW'(1)) begin
              w_state_nxt = S_IDLE;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold_cnt - HW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_pulse_nxt  = 1'b0;
    w_sticky_nxt = o_err_sticky;
    w_cnt_nxt    = o_err_cnt;
    w_first_nxt  = o_first_src;
    w_err_nxt    = (w_state_nxt == S_HOLD);
    if (i_clear) begin
      w_sticky_nxt = 1'b0;
      w_cnt_nxt    = '0;
      w_first_nxt  = '0;
    end else if (w_hit) begin
      w_pulse_nxt = 1'b1;
      if (o_err_cnt != {CNTW{1'b1}}) begin
        w_cnt_nxt = o_err_cnt + CNTW'(1);
      end
      if (!o_err_sticky) begin
        w_sticky_nxt = 1'b1;
        w_first_nxt  = r_err_r;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err        <= 1'b0;
      o_err_pulse  <= 1'b0;
      o_err_sticky <= 1'b0;
      o_err_cnt    <= '0;
      o_first_src  <= '0;
    end else begin
      o_err        <= w_err_nxt;
      o_err_pulse  <= w_pulse_nxt;
      o_err_sticky <= w_sticky_nxt;
      o_err_cnt    <= w_cnt_nxt;
      o_first_src  <= w_first_nxt;
    end
  end

endmodule
